// File: rtl/path_pkg.sv
// rtl/path_pkg.sv - shared directions, turn codes, error codes and FSM states for path_turn_sequencer
// Used by the top in both builds, with or without PATH_RETURN_TRIP_EN.
package path_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [1:0] TURN_STRAIGHT = 2'd0;
  localparam logic [1:0] TURN_RIGHT    = 2'd1;
  localparam logic [1:0] TURN_UTURN    = 2'd2;
  localparam logic [1:0] TURN_LEFT     = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NOT_ADJ  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_NODE,
    ST_LOOKUP,
    ST_RESOLVE,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Clockwise direction codes make the relative turn a plain 2-bit difference.
  function automatic logic [1:0] rel_turn(input logic [1:0] ndir, input logic [1:0] heading);
    return ndir - heading;
  endfunction

endpackage

// File: rtl/path_turn_sequencer_adj_table.sv
// rtl/path_turn_sequencer_adj_table.sv - node adjacency map, one write port, registered 4-wide row read
// Only the valid bits are reset; neighbour IDs are don't-care until written.
module adj_table #(
  parameter int NODE_W    = 5,
  parameter int NUM_NODES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [NODE_W-1:0]      wr_node,
  input  logic [1:0]             wr_dir,
  input  logic                   wr_vld,
  input  logic [NODE_W-1:0]      wr_data,
  input  logic [NODE_W-1:0]      rd_node,
  output logic [3:0]             rd_vld,
  output logic [3:0][NODE_W-1:0] rd_data
);

  logic [3:0]             vld_mem  [NUM_NODES];
  logic [3:0][NODE_W-1:0] node_mem [NUM_NODES];
  logic                   wr_ok;
  logic                   rd_ok;

  assign wr_ok = wr_en && (int'(wr_node) < NUM_NODES);
  assign rd_ok = int'(rd_node) < NUM_NODES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NODES; i++) vld_mem[i] <= '0;
    end else if (wr_ok) begin
      vld_mem[wr_node][wr_dir] <= wr_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) node_mem[wr_node][wr_dir] <= wr_data;
  end

  // Out-of-range rows read back as "no edges" so the lookup fails cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= '0;
      rd_data <= '0;
    end else if (rd_ok) begin
      rd_vld  <= vld_mem[rd_node];
      rd_data <= node_mem[rd_node];
    end else begin
      rd_vld  <= '0;
    end
  end

endmodule

// File: rtl/path_turn_sequencer.sv
// rtl/path_turn_sequencer.sv - path-to-turn sequencer: path/map load, per-node turn emission
// Optional PATH_RETURN_TRIP_EN walks the stored path back to its first node before DONE.
module path_turn_sequencer
  import path_pkg::*;
#(
  parameter int NODE_W    = 5,
  parameter int NUM_NODES = 30,
  parameter int MAX_PATH  = 16,
  parameter int INIT_DIR  = 0
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              adj_wr_en,
  input  logic [NODE_W-1:0] adj_wr_node,
  input  logic [1:0]        adj_wr_dir,
  input  logic              adj_wr_vld,
  input  logic [NODE_W-1:0] adj_wr_data,
  input  logic              path_wr_valid,
  output logic              path_wr_ready,
  input  logic [NODE_W-1:0] path_wr_node,
  input  logic              path_wr_last,
  input  logic              abort,
  input  logic              node_changed,
  output logic              turn_valid,
  input  logic              turn_ready,
  output logic [1:0]        turn_flag,
  output logic [NODE_W-1:0] realtime_pos,
  output logic              busy,
  output logic              path_done,
  output logic [1:0]        err_code
);

  localparam int CW = $clog2(MAX_PATH + 1);
  localparam int JW = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

  state_t                 state, state_n;
  logic [CW-1:0]          count, count_base, count_inc;
  logic [JW-1:0]          j, j_next, j_prev;
  logic [NODE_W-1:0]      path [MAX_PATH];
  logic [NODE_W-1:0]      cur, nxt;
  logic [1:0]             heading, ndir, ndir_c;
  logic                   rev, turnback, at_end, beat, hit;
  logic [3:0]             row_vld;
  logic [3:0][NODE_W-1:0] row_data;

  adj_table #(.NODE_W(NODE_W), .NUM_NODES(NUM_NODES)) u_adj (
    .clk     (clk_50M),
    .rst_n   (rst_n),
    .wr_en   (adj_wr_en),
    .wr_node (adj_wr_node),
    .wr_dir  (adj_wr_dir),
    .wr_vld  (adj_wr_vld),
    .wr_data (adj_wr_data),
    .rd_node (cur),
    .rd_vld  (row_vld),
    .rd_data (row_data)
  );

  assign turn_valid = (state == ST_EMIT);
  assign busy       = (state != ST_IDLE);
  assign path_done  = (state == ST_DONE);

  assign beat       = path_wr_valid && path_wr_ready;
  assign count_base = (state == ST_IDLE) ? '0 : count;
  assign count_inc  = count_base + CW'(1);
  assign j_next     = j + JW'(1);
  assign j_prev     = j - JW'(1);
  assign at_end     = rev ? (j == '0) : ((CW'(j) + CW'(1)) == count);

`ifdef PATH_RETURN_TRIP_EN
  assign turnback = !rev && at_end && (j != '0);
`else
  assign turnback = 1'b0;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (beat) begin
          if (path_wr_last)                  state_n = ST_WAIT_NODE;
          else if (count_inc == CW'(MAX_PATH)) state_n = ST_ERR;
          else                               state_n = ST_LOAD;
        end
      end
      ST_WAIT_NODE: if (node_changed) state_n = (at_end && !turnback) ? ST_DONE : ST_LOOKUP;
      ST_LOOKUP:    state_n = ST_RESOLVE;
      ST_RESOLVE:   state_n = hit ? ST_EMIT : ST_ERR;
      ST_EMIT:      if (turn_ready) state_n = ST_WAIT_NODE;
      default:      ;
    endcase
    if (abort) state_n = ST_IDLE;
  end

  // Lowest direction index wins when several entries name the same neighbour.
  always_comb begin
    hit    = 1'b0;
    ndir_c = DIR_N;
    for (int d = 3; d >= 0; d--) begin
      if (row_vld[d] && (row_data[d] == nxt)) begin
        hit    = 1'b1;
        ndir_c = 2'(d);
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (beat && !abort) path[count_base[JW-1:0]] <= path_wr_node;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      j             <= '0;
      cur           <= '0;
      nxt           <= '0;
      heading       <= 2'(INIT_DIR);
      ndir          <= DIR_N;
      rev           <= 1'b0;
      turn_flag     <= TURN_STRAIGHT;
      realtime_pos  <= '0;
      err_code      <= ERR_NONE;
      path_wr_ready <= 1'b0;
    end else begin
      path_wr_ready <= (state_n == ST_IDLE) || (state_n == ST_LOAD);
      if (!abort) begin
        case (state)
          ST_IDLE, ST_LOAD: begin
            if (beat) begin
              count <= count_inc;
              if (state == ST_IDLE) err_code <= ERR_NONE;
              if (path_wr_last) begin
                j       <= '0;
                rev     <= 1'b0;
                heading <= 2'(INIT_DIR);
              end else if (count_inc == CW'(MAX_PATH)) begin
                err_code <= ERR_OVERFLOW;
              end
            end
          end
          ST_WAIT_NODE: begin
            if (node_changed) begin
              realtime_pos <= path[j];
              cur          <= path[j];
              nxt          <= (rev || turnback) ? path[j_prev] : path[j_next];
              if (turnback) rev <= 1'b1;
            end
          end
          ST_LOOKUP: if (node_changed) err_code <= ERR_OVERRUN;
          ST_RESOLVE: begin
            if (node_changed) err_code <= ERR_OVERRUN;
            if (hit) begin
              turn_flag <= rel_turn(ndir_c, heading);
              ndir      <= ndir_c;
            end else begin
              err_code  <= ERR_NOT_ADJ;
            end
          end
          ST_EMIT: begin
            if (node_changed) err_code <= ERR_OVERRUN;
            if (turn_ready) begin
              heading <= ndir;
              j       <= rev ? j_prev : j_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_path_turn_sequencer.sv
// tb/tb_path_turn_sequencer.sv - randomized and directed bench for path_turn_sequencer
// Expectations follow PATH_RETURN_TRIP_EN when it is defined for the build.
module tb_path_turn_sequencer;

  localparam int NODE_W    = 5;
  localparam int NUM_NODES = 30;
  localparam int MAX_PATH  = 16;
  localparam int INIT_DIR  = 0;
`ifdef PATH_RETURN_TRIP_EN
  localparam bit RETURN_TRIP = 1'b1;
`else
  localparam bit RETURN_TRIP = 1'b0;
`endif

  logic              clk_50M = 1'b0;
  logic              rst_n = 1'b0;
  logic              adj_wr_en = 1'b0;
  logic [NODE_W-1:0] adj_wr_node = '0;
  logic [1:0]        adj_wr_dir = '0;
  logic              adj_wr_vld = 1'b0;
  logic [NODE_W-1:0] adj_wr_data = '0;
  logic              path_wr_valid = 1'b0;
  logic              path_wr_ready;
  logic [NODE_W-1:0] path_wr_node = '0;
  logic              path_wr_last = 1'b0;
  logic              abort = 1'b0;
  logic              node_changed = 1'b0;
  logic              turn_valid;
  logic              turn_ready = 1'b0;
  logic [1:0]        turn_flag;
  logic [NODE_W-1:0] realtime_pos;
  logic              busy;
  logic              path_done;
  logic [1:0]        err_code;

  path_turn_sequencer #(
    .NODE_W(NODE_W), .NUM_NODES(NUM_NODES), .MAX_PATH(MAX_PATH), .INIT_DIR(INIT_DIR)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .adj_wr_en(adj_wr_en), .adj_wr_node(adj_wr_node), .adj_wr_dir(adj_wr_dir),
    .adj_wr_vld(adj_wr_vld), .adj_wr_data(adj_wr_data),
    .path_wr_valid(path_wr_valid), .path_wr_ready(path_wr_ready),
    .path_wr_node(path_wr_node), .path_wr_last(path_wr_last),
    .abort(abort), .node_changed(node_changed),
    .turn_valid(turn_valid), .turn_ready(turn_ready), .turn_flag(turn_flag),
    .realtime_pos(realtime_pos), .busy(busy), .path_done(path_done), .err_code(err_code)
  );

  always #10 clk_50M = ~clk_50M;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          map_vld  [32][4];
  logic [4:0]  map_node [32][4];
  logic [4:0]  plan[$];
  int          got_turns[$];
  int          spec_turns[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic adj_wr(input int node, input int dir, input bit vld, input int data);
    adj_wr_en   = 1'b1;
    adj_wr_node = node[4:0];
    adj_wr_dir  = dir[1:0];
    adj_wr_vld  = vld;
    adj_wr_data = data[4:0];
    map_vld[node][dir]  = vld;
    map_node[node][dir] = data[4:0];
    tick(1);
    adj_wr_en = 1'b0;
  endtask

  task automatic load_path(input logic [4:0] p[$], input bit with_last);
    int w;
    for (int i = 0; i < p.size(); i++) begin
      path_wr_valid = 1'b1;
      path_wr_node  = p[i];
      path_wr_last  = with_last && (i == p.size() - 1);
      w = 0;
      @(negedge clk_50M);
      while (!path_wr_ready && w < 20) begin
        @(negedge clk_50M);
        w++;
      end
      if (!path_wr_ready) check("load_ready_timeout", path_wr_ready, 1);
      tick(1);
      path_wr_valid = 1'b0;
      path_wr_last  = 1'b0;
      tick($urandom_range(0, 2));
    end
  endtask

  task automatic pulse_nc();
    node_changed = 1'b1;
    tick(1);
    node_changed = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
  endtask

  // Reference: list of visited path indices, then a heading walk over the bench's copy of the map.
  task automatic model(input logic [4:0] p[$], output int turns[$], output bit ends_err,
                       output logic [4:0] last_pos);
    int seq[$];
    int hd;
    int d;
    int here;
    int there;
    hd = INIT_DIR;
    turns = {};
    ends_err = 1'b0;
    last_pos = '0;
    for (int i = 0; i < p.size(); i++) seq.push_back(i);
    if (RETURN_TRIP) for (int i = p.size() - 2; i >= 0; i--) seq.push_back(i);
    for (int k = 0; k < seq.size(); k++) begin
      here = int'(p[seq[k]]);
      last_pos = p[seq[k]];
      if (k == seq.size() - 1) return;
      there = int'(p[seq[k+1]]);
      d = -1;
      if (here < NUM_NODES)
        for (int c = 0; c < 4; c++)
          if (d < 0 && map_vld[here][c] && int'(map_node[here][c]) == there) d = c;
      if (d < 0) begin
        ends_err = 1'b1;
        return;
      end
      turns.push_back((d - hd + 4) % 4);
      hd = d;
    end
  endtask

  task automatic run_traversal(input logic [4:0] p[$], input bit inject);
    int         turns[$];
    bit         ends_err;
    logic [4:0] last_pos;
    int         w;
    int         stall;
    bit         injected;
    logic [1:0] held;
    model(p, turns, ends_err, last_pos);
    injected  = inject && (turns.size() > 0);
    got_turns = {};
    for (int k = 0; k < turns.size(); k++) begin
      pulse_nc();
      w = 0;
      @(negedge clk_50M);
      while (!turn_valid && w < 10) begin
        @(negedge clk_50M);
        w++;
      end
      check("turn_valid_rise", turn_valid, 1);
      if (!turn_valid) return;
      check("turn_flag", turn_flag, turns[k]);
      got_turns.push_back(int'(turn_flag));
      held  = turn_flag;
      stall = (inject && k == 0) ? 10 : $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        node_changed = inject && (k == 0) && (s == 4);
        @(negedge clk_50M);
        check("turn_hold_valid", turn_valid, 1);
        check("turn_hold_flag", turn_flag, held);
      end
      node_changed = 1'b0;
      turn_ready   = 1'b1;
      tick(1);
      turn_ready   = 1'b0;
      tick($urandom_range(0, 2));
    end
    pulse_nc();
    tick(3);
    @(negedge clk_50M);
    check("end_pos", realtime_pos, last_pos);
    check("end_turn_valid", turn_valid, 0);
    if (ends_err) begin
      check("end_err_not_adj", err_code, 1);
      check("end_not_done", path_done, 0);
    end else begin
      check("end_done", path_done, 1);
      check("end_err", err_code, injected ? 2 : 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int w;
    int len;
    int cand[$];
    int cur;
    int k;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    check("rst_ready", path_wr_ready, 0);
    check("rst_turn_valid", turn_valid, 0);
    check("rst_turn_flag", turn_flag, 0);
    check("rst_pos", realtime_pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", path_done, 0);
    check("rst_err", err_code, 0);
    @(posedge clk_50M);
    #1 rst_n = 1'b1;
    tick(2);
    @(negedge clk_50M);
    check("idle_ready", path_wr_ready, 1);

    adj_wr(0, 0, 1, 1); adj_wr(1, 2, 1, 0); adj_wr(1, 3, 1, 2); adj_wr(2, 1, 1, 1);
    adj_wr(2, 0, 1, 8); adj_wr(8, 2, 1, 2); adj_wr(8, 3, 1, 7); adj_wr(7, 1, 1, 8);

    plan = {5'd0, 5'd1, 5'd2, 5'd8, 5'd7};
    load_path(plan, 1'b1);
    run_traversal(plan, 1'b1);
`ifdef PATH_RETURN_TRIP_EN
    spec_turns = {0, 3, 1, 3, 2, 1, 3, 1};
`else
    spec_turns = {0, 3, 1, 3};
`endif
    check("dir_turn_count", got_turns.size(), spec_turns.size());
    for (int i = 0; i < spec_turns.size(); i++)
      if (i < got_turns.size()) check("dir_turn", got_turns[i], spec_turns[i]);
    do_abort();

`ifdef PATH_RETURN_TRIP_EN
    plan = {5'd0, 5'd1, 5'd2};
    load_path(plan, 1'b1);
    run_traversal(plan, 1'b0);
    spec_turns = {0, 3, 2, 1};
    check("rt_turn_count", got_turns.size(), spec_turns.size());
    for (int i = 0; i < spec_turns.size(); i++)
      if (i < got_turns.size()) check("rt_turn", got_turns[i], spec_turns[i]);
    check("rt_home", realtime_pos, 0);
    do_abort();
`endif

    plan = {5'd0, 5'd5};
    load_path(plan, 1'b1);
    run_traversal(plan, 1'b0);
    check("notadj_err", err_code, 1);
    do_abort();

    plan = {};
    for (int i = 0; i < MAX_PATH; i++) plan.push_back(5'($urandom_range(0, 29)));
    load_path(plan, 1'b0);
    @(negedge clk_50M);
    check("ovf_ready", path_wr_ready, 0);
    check("ovf_err", err_code, 3);
    check("ovf_busy", busy, 1);
    path_wr_valid = 1'b1;
    path_wr_node  = 5'd3;
    repeat (3) @(negedge clk_50M);
    check("ovf_ready_17", path_wr_ready, 0);
    check("ovf_err_17", err_code, 3);
    path_wr_valid = 1'b0;
    do_abort();

    plan = {5'd1, 5'd2, 5'd8};
    load_path(plan, 1'b1);
    pulse_nc();
    w = 0;
    @(negedge clk_50M);
    while (!turn_valid && w < 10) begin
      @(negedge clk_50M);
      w++;
    end
    check("pre_rst_emit", turn_valid, 1);
    check("pre_rst_flag", turn_flag, 3);
    check("pre_rst_pos", realtime_pos, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", path_wr_ready, 0);
    check("mid_rst_valid", turn_valid, 0);
    check("mid_rst_flag", turn_flag, 0);
    check("mid_rst_pos", realtime_pos, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", path_done, 0);
    check("mid_rst_err", err_code, 0);
    for (int n = 0; n < 32; n++) for (int d = 0; d < 4; d++) map_vld[n][d] = 1'b0;
    @(posedge clk_50M);
    #1 rst_n = 1'b1;
    tick(2);
    plan = {5'd1, 5'd2};
    load_path(plan, 1'b1);
    run_traversal(plan, 1'b0);
    check("replay_err", err_code, 1);
    do_abort();

    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < NUM_NODES; n++)
        for (int d = 0; d < 4; d++)
          adj_wr(n, d, ($urandom_range(0, 2) != 0), $urandom_range(0, 30));
      plan = {};
      plan.push_back(5'($urandom_range(0, 29)));
      len = $urandom_range(1, MAX_PATH);
      for (int i = 1; i < len; i++) begin
        cur  = int'(plan[i-1]);
        cand = {};
        if (cur < NUM_NODES)
          for (int d = 0; d < 4; d++) if (map_vld[cur][d]) cand.push_back(int'(map_node[cur][d]));
        if (cand.size() > 0 && $urandom_range(0, 7) != 0) begin
          k = $urandom_range(0, cand.size() - 1);
          plan.push_back(5'(cand[k]));
        end else begin
          plan.push_back(5'($urandom_range(0, 31)));
        end
      end
      load_path(plan, 1'b1);
      run_traversal(plan, ($urandom_range(0, 3) == 0));
      do_abort();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
